uart_rx_param: RTL and testbench

//   Parametrised UART receiver. It samples the serial line at CLKS_PER_BIT clocks per bit and

---
 rtl/uart_rx_param.sv | 196 +++++++++++++++++++
 tb/tb_uart_rx_param.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: 2-flop synchroniser, 3-sample majority vote per bit,
// configurable word length / parity / stop bits / bit order, valid/ready word output.
// Ports:
//   rxclk      - clock
//   rst_n      - synchronous active-low reset
//   rxclken    - bit-timing enable; line FSM, counters and vote samples advance only when 1
//   rx         - asynchronous serial line, idle high
//   dout       - received word, stable while dout_valid=1
//   dout_valid - word available
//   dout_ready - consumer accepts the word
//   parity_err - parity mismatch for the held word (qualified by dout_valid)
//   frame_err  - a stop bit of the held word was sampled 0 (qualified by dout_valid)
//   overrun    - 1-cycle pulse when a completed word is dropped because dout is full
//   busy       - line FSM is not idle
module uart_rx_param #(
  parameter int unsigned CLKS_PER_BIT = 1085,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned PARITY_EN    = 0,
  parameter int unsigned PARITY_ODD   = 0,
  parameter int unsigned STOP_BITS    = 1,
  parameter int unsigned MSB_FIRST    = 1
) (
  input  logic                 rxclk,
  input  logic                 rst_n,
  input  logic                 rxclken,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] dout,
  output logic                 dout_valid,
  input  logic                 dout_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int unsigned CW   = $clog2(CLKS_PER_BIT);
  localparam int unsigned HALF = (CLKS_PER_BIT - 1) / 2;
  localparam int unsigned BW   = $clog2(DATA_BITS + 1);

  localparam logic [CW-1:0] CNT_HALF  = CW'(HALF);
  localparam logic [CW-1:0] CNT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);
  localparam logic          ODD       = (PARITY_ODD != 0);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} state_e;

  state_e                 state_q, state_d;
  logic                   rx_meta_q, rxs_q;
  logic [1:0]             smp_q;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [BW-1:0]          bit_q, bit_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic                   perr_q, perr_d, ferr_q, ferr_d;
  logic [DATA_BITS-1:0]   dout_q, dout_d;
  logic                   valid_q, valid_d;
  logic                   perr_out_q, perr_out_d, ferr_out_q, ferr_out_d;
  logic                   ovr_q, ovr_d;
  logic                   busy_q;
  logic                   vote_c, at_half_c, at_last_c, done_c;

  // rxs_q and smp_q hold the last three line samples; vote taken at the decision count
  assign vote_c    = (smp_q[1] & smp_q[0]) | (smp_q[1] & rxs_q) | (smp_q[0] & rxs_q);
  assign at_half_c = (cnt_q == CNT_HALF);
  assign at_last_c = (cnt_q == CNT_LAST);

  // Synchroniser resets to idle-high so reset never looks like a start bit
  always_ff @(posedge rxclk) begin
    if (!rst_n) begin
      rx_meta_q <= 1'b1;
      rxs_q     <= 1'b1;
      smp_q     <= 2'b11;
    end else begin
      rx_meta_q <= rx;
      rxs_q     <= rx_meta_q;
      if (rxclken) smp_q <= {smp_q[0], rxs_q};
    end
  end

  // State register
  always_ff @(posedge rxclk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (rxclken) begin
      case (state_q)
        S_IDLE:  if (!rxs_q) state_d = S_START;
        S_START: if (at_half_c) state_d = vote_c ? S_IDLE : S_DATA;
        S_DATA:  if (at_last_c && (bit_q == DATA_LAST))
                   state_d = (PARITY_EN != 0) ? S_PAR : S_STOP;
        S_PAR:   if (at_last_c) state_d = S_STOP;
        S_STOP:  if (at_last_c && (bit_q == STOP_LAST)) state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Bit timing, data assembly and per-frame error tracking
  always_comb begin
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    perr_d  = perr_q;
    ferr_d  = ferr_q;
    done_c  = 1'b0;
    if (rxclken) begin
      cnt_d = cnt_q + CW'(1);
      case (state_q)
        S_IDLE: begin
          cnt_d  = '0;
          bit_d  = '0;
          perr_d = 1'b0;
          ferr_d = 1'b0;
        end
        S_START: if (at_half_c) cnt_d = '0;
        S_DATA: if (at_last_c) begin
          cnt_d   = '0;
          shift_d = (MSB_FIRST != 0) ? {shift_q[DATA_BITS-2:0], vote_c}
                                     : {vote_c, shift_q[DATA_BITS-1:1]};
          bit_d   = (bit_q == DATA_LAST) ? '0 : bit_q + BW'(1);
        end
        S_PAR: if (at_last_c) begin
          cnt_d  = '0;
          perr_d = ((^shift_q) ^ vote_c) != ODD;
        end
        S_STOP: if (at_last_c) begin
          cnt_d = '0;
          bit_d = bit_q + BW'(1);
          if (!vote_c) ferr_d = 1'b1;
          if (bit_q == STOP_LAST) done_c = 1'b1;
        end
        default: cnt_d = '0;
      endcase
    end
  end

  // Output holding register: load on completion if empty or being drained, else flag overrun
  always_comb begin
    dout_d     = dout_q;
    valid_d    = valid_q;
    perr_out_d = perr_out_q;
    ferr_out_d = ferr_out_q;
    ovr_d      = 1'b0;
    if (done_c && (!valid_q || dout_ready)) begin
      dout_d     = shift_q;
      valid_d    = 1'b1;
      perr_out_d = perr_q;
      ferr_out_d = ferr_d;
    end else if (done_c) begin
      ovr_d = 1'b1;
    end else if (valid_q && dout_ready) begin
      valid_d = 1'b0;
    end
  end

  // Datapath and output registers
  always_ff @(posedge rxclk) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      dout_q     <= '0;
      valid_q    <= 1'b0;
      perr_out_q <= 1'b0;
      ferr_out_q <= 1'b0;
      ovr_q      <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
      dout_q     <= dout_d;
      valid_q    <= valid_d;
      perr_out_q <= perr_out_d;
      ferr_out_q <= ferr_out_d;
      ovr_q      <= ovr_d;
      busy_q     <= (state_d != S_IDLE);
    end
  end

  assign dout       = dout_q;
  assign dout_valid = valid_q;
  assign parity_err = perr_out_q;
  assign frame_err  = ferr_out_q;
  assign overrun    = ovr_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_uart_rx_param.sv
// Scoreboard bench for uart_rx_param: three receivers (8N1 MSB-first, 8E1 MSB-first,
// 8N2 LSB-first) on separate lines; stimulus pushes expected words, a monitor pops and
// compares each presented word and then accepts it.
module tb_uart_rx_param;

  localparam int CPB = 16;

  typedef struct packed {
    logic [7:0] d;
    logic       pe;
    logic       fe;
  } exp_t;

  logic       rxclk = 1'b0;
  logic       rst_n;
  logic       rxclken;
  logic       rx_l   [3];
  logic       hold   [3];
  logic       rdy    [3] = '{1'b0, 1'b0, 1'b0};
  logic [7:0] dout_w [3];
  logic       val_w  [3];
  logic       pe_w   [3];
  logic       fe_w   [3];
  logic       ovr_w  [3];
  logic       busy_w [3];

  exp_t q_a[$];
  exp_t q_b[$];
  exp_t q_c[$];

  int checks  = 0;
  int errors  = 0;
  int cyc     = 0;
  int lat_cyc = 0;
  int ovr_cnt [3] = '{0, 0, 0};

  always #5 rxclk = ~rxclk;
  always @(posedge rxclk) cyc <= cyc + 1;

  uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0),
                  .STOP_BITS(1), .MSB_FIRST(1)) u_a (
    .rxclk(rxclk), .rst_n(rst_n), .rxclken(rxclken), .rx(rx_l[0]),
    .dout(dout_w[0]), .dout_valid(val_w[0]), .dout_ready(rdy[0]),
    .parity_err(pe_w[0]), .frame_err(fe_w[0]), .overrun(ovr_w[0]), .busy(busy_w[0]));

  uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0),
                  .STOP_BITS(1), .MSB_FIRST(1)) u_b (
    .rxclk(rxclk), .rst_n(rst_n), .rxclken(rxclken), .rx(rx_l[1]),
    .dout(dout_w[1]), .dout_valid(val_w[1]), .dout_ready(rdy[1]),
    .parity_err(pe_w[1]), .frame_err(fe_w[1]), .overrun(ovr_w[1]), .busy(busy_w[1]));

  uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0),
                  .STOP_BITS(2), .MSB_FIRST(0)) u_c (
    .rxclk(rxclk), .rst_n(rst_n), .rxclken(rxclken), .rx(rx_l[2]),
    .dout(dout_w[2]), .dout_valid(val_w[2]), .dout_ready(rdy[2]),
    .parity_err(pe_w[2]), .frame_err(fe_w[2]), .overrun(ovr_w[2]), .busy(busy_w[2]));

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic int qsize(input int ch);
    case (ch)
      0:       return q_a.size();
      1:       return q_b.size();
      default: return q_c.size();
    endcase
  endfunction

  task automatic push(input int ch, input logic [7:0] d, input logic pe, input logic fe);
    exp_t e;
    e = '{d: d, pe: pe, fe: fe};
    case (ch)
      0:       q_a.push_back(e);
      1:       q_b.push_back(e);
      default: q_c.push_back(e);
    endcase
  endtask

  // Monitor: compare a presented word against the scoreboard, accept it, then expect valid low
  always @(negedge rxclk) begin
    exp_t e;
    logic have;
    for (int ch = 0; ch < 3; ch++) begin
      if (ovr_w[ch] === 1'b1) ovr_cnt[ch]++;
      if (rdy[ch]) begin
        rdy[ch] = 1'b0;
        chk($sformatf("accept_clears_ch%0d", ch), 32'(val_w[ch]), 32'd0);
      end else if (val_w[ch] === 1'b1 && !hold[ch]) begin
        have = 1'b0;
        e    = '0;
        case (ch)
          0:       if (q_a.size() > 0) begin e = q_a.pop_front(); have = 1'b1; end
          1:       if (q_b.size() > 0) begin e = q_b.pop_front(); have = 1'b1; end
          default: if (q_c.size() > 0) begin e = q_c.pop_front(); have = 1'b1; end
        endcase
        checks++;
        if (!have) begin
          errors++;
          $display("FAIL unexpected_word_ch%0d: got dout=%02h, expected no word", ch, dout_w[ch]);
        end else if ({dout_w[ch], pe_w[ch], fe_w[ch]} !== {e.d, e.pe, e.fe}) begin
          errors++;
          $display("FAIL word_ch%0d: got dout=%02h pe=%b fe=%b expected dout=%02h pe=%b fe=%b",
                   ch, dout_w[ch], pe_w[ch], fe_w[ch], e.d, e.pe, e.fe);
        end
        if (ch == 0) lat_cyc = cyc;
        rdy[ch] = 1'b1;
      end
    end
  end

  // One bit period; optional 1-clock inversion at edge glitch_k, optional enable freeze before edge freeze_k
  task automatic send_bit(input int ch, input logic v, input int glitch_k, input int freeze_k);
    for (int k = 1; k <= CPB; k++) begin
      if (k == freeze_k) begin
        rxclken = 1'b0;
        repeat (40) @(negedge rxclk);
        rxclken = 1'b1;
      end
      rx_l[ch] = (k == glitch_k) ? ~v : v;
      @(negedge rxclk);
    end
  endtask

  task automatic send_frame(input int ch, input logic [7:0] data, input bit msb,
                            input bit has_par, input logic par, input int nstop,
                            input logic stop2, input int glitch_bit, input int freeze_bit);
    logic b;
    send_bit(ch, 1'b0, 0, 0);
    for (int i = 0; i < 8; i++) begin
      b = msb ? data[7-i] : data[i];
      send_bit(ch, b, (i == glitch_bit) ? 8 : 0, (i == freeze_bit) ? 5 : 0);
    end
    if (has_par) send_bit(ch, par, 0, 0);
    send_bit(ch, 1'b1, 0, 0);
    if (nstop == 2) send_bit(ch, stop2, 0, 0);
    rx_l[ch] = 1'b1;
  endtask

  task automatic wait_drain(input int ch);
    int n;
    n = 0;
    while ((qsize(ch) != 0 || rdy[ch]) && n < 600) begin
      @(negedge rxclk);
      n++;
    end
    chk($sformatf("drain_ch%0d", ch), 32'(qsize(ch)), 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int c0;
    int base;
    int seen;
    rst_n   = 1'b0;
    rxclken = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rx_l[i] = 1'b1;
      hold[i] = 1'b0;
    end
    repeat (3) @(negedge rxclk);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rst_valid_ch%0d", i), 32'(val_w[i]), 32'd0);
      chk($sformatf("rst_dout_ch%0d", i), 32'(dout_w[i]), 32'd0);
      chk($sformatf("rst_flags_ch%0d", i), 32'({pe_w[i], fe_w[i], ovr_w[i], busy_w[i]}), 32'd0);
    end
    rst_n = 1'b1;
    repeat (5) @(negedge rxclk);

    // 8N1 MSB-first 0xA5 and decision-to-valid latency
    push(0, 8'hA5, 1'b0, 1'b0);
    c0 = cyc;
    send_frame(0, 8'hA5, 1'b1, 1'b0, 1'b0, 1, 1'b1, -1, -1);
    wait_drain(0);
    chk("latency_ch0", 32'(lat_cyc - c0), 32'd155);

    // Even parity: 0x37 has five ones, so the correct parity bit is 1
    push(1, 8'h37, 1'b1, 1'b0);
    send_frame(1, 8'h37, 1'b1, 1'b1, 1'b0, 1, 1'b1, -1, -1);
    push(1, 8'h37, 1'b0, 1'b0);
    send_frame(1, 8'h37, 1'b1, 1'b1, 1'b1, 1, 1'b1, -1, -1);
    wait_drain(1);

    // 8N2 LSB-first: second stop bit low flags a framing error, then a clean frame
    push(2, 8'h3C, 1'b0, 1'b1);
    send_frame(2, 8'h3C, 1'b0, 1'b0, 1'b0, 2, 1'b0, -1, -1);
    repeat (40) @(negedge rxclk);
    push(2, 8'h3C, 1'b0, 1'b0);
    send_frame(2, 8'h3C, 1'b0, 1'b0, 1'b0, 2, 1'b1, -1, -1);
    wait_drain(2);

    // 1-clock glitch at the middle sample of data bit 2 is outvoted
    push(0, 8'h96, 1'b0, 1'b0);
    send_frame(0, 8'h96, 1'b1, 1'b0, 1'b0, 1, 1'b1, 2, -1);
    wait_drain(0);

    // Short low pulse: START rejects it, busy falls, no word
    rx_l[0] = 1'b0;
    repeat (3) @(negedge rxclk);
    rx_l[0] = 1'b1;
    chk("glitch_busy_high", 32'(busy_w[0]), 32'd1);
    repeat (12) @(negedge rxclk);
    chk("glitch_busy_low", 32'(busy_w[0]), 32'd0);
    seen = 0;
    repeat (200) begin
      @(negedge rxclk);
      if (val_w[0] === 1'b1) seen++;
    end
    chk("glitch_no_word", 32'(seen), 32'd0);

    // Back-to-back words while the consumer stalls: first held, two overruns
    hold[0] = 1'b1;
    base = ovr_cnt[0];
    push(0, 8'h11, 1'b0, 1'b0);
    send_frame(0, 8'h11, 1'b1, 1'b0, 1'b0, 1, 1'b1, -1, -1);
    send_frame(0, 8'h22, 1'b1, 1'b0, 1'b0, 1, 1'b1, -1, -1);
    send_frame(0, 8'h33, 1'b1, 1'b0, 1'b0, 1, 1'b1, -1, -1);
    repeat (4) @(negedge rxclk);
    chk("overrun_pulses", 32'(ovr_cnt[0] - base), 32'd2);
    chk("hold_valid", 32'(val_w[0]), 32'd1);
    chk("hold_dout", 32'(dout_w[0]), 32'h11);
    hold[0] = 1'b0;
    wait_drain(0);
    push(0, 8'h44, 1'b0, 1'b0);
    send_frame(0, 8'h44, 1'b1, 1'b0, 1'b0, 1, 1'b1, -1, -1);
    wait_drain(0);

    // Enable held low for 40 cycles inside data bit 4 with the line frozen
    push(0, 8'hC3, 1'b0, 1'b0);
    send_frame(0, 8'hC3, 1'b1, 1'b0, 1'b0, 1, 1'b1, -1, 4);
    wait_drain(0);

    // Reset in the middle of DATA discards the partial word
    send_bit(0, 1'b0, 0, 0);
    send_bit(0, 1'b1, 0, 0);
    send_bit(0, 1'b0, 0, 0);
    send_bit(0, 1'b1, 0, 0);
    chk("midframe_busy", 32'(busy_w[0]), 32'd1);
    rst_n   = 1'b0;
    rx_l[0] = 1'b1;
    @(negedge rxclk);
    rst_n = 1'b1;
    chk("midrst_dout", 32'(dout_w[0]), 32'd0);
    chk("midrst_outs", 32'({val_w[0], pe_w[0], fe_w[0], ovr_w[0], busy_w[0]}), 32'd0);
    repeat (40) @(negedge rxclk);
    push(0, 8'h5A, 1'b0, 1'b0);
    send_frame(0, 8'h5A, 1'b1, 1'b0, 1'b0, 1, 1'b1, -1, -1);
    wait_drain(0);

    repeat (20) @(negedge rxclk);
    for (int i = 0; i < 3; i++) chk($sformatf("final_empty_ch%0d", i), 32'(qsize(i)), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
